// File: rtl/vga_texto_render.sv
// Eight-cell text overlay renderer: two pixel_tick stages from coordinates to rgb, text latched per frame.
// Optional build macro BLINK_CURSOR_EN adds a frame counter that blinks the cell at cursor_pos.
module vga_texto_render #(
    parameter int          X0 = 256,
    parameter int          Y0 = 224,
    parameter logic [11:0] FG = 12'hFFF,
    parameter logic [11:0] BG = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [47:0] text_in,
    input  logic [2:0]  cursor_pos,
    output logic [3:0]  sel_caracter,
    output logic [1:0]  AD,
    output logic [3:0]  lsby,
    input  logic [7:0]  data,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync
);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + 64);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + 16);

    logic [47:0] r_shadow;
    logic        r_vs_prev;

    logic [3:0]  r_sel;
    logic [1:0]  r_ad;
    logic [3:0]  r_lsby;
    logic [2:0]  r_col_a;
    logic [2:0]  r_cell_a;
    logic        r_in_win_a;
    logic        r_video_a;
    logic        r_hs_a;
    logic        r_vs_a;

    logic        r_pix_b;
    logic        r_in_win_b;
    logic        r_video_b;
    logic        r_hs_b;
    logic        r_vs_b;

    logic        w_in_win;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic [2:0]  w_cell;
    logic [5:0]  w_code;
    logic        w_frame_evt;
    logic        w_glyph_bit;
    logic        w_pix;

    // Compare in 11 bits so coordinates left of/above the window never wrap into it.
    assign w_in_win = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                      ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
    assign w_dx        = pixel_x - X_LO[9:0];
    assign w_dy        = pixel_y - Y_LO[9:0];
    assign w_cell      = w_dx[5:3];
    assign w_frame_evt = r_vs_prev & ~vsync_in;

    always_comb begin
        w_code = '0;
        for (int k = 0; k < 8; k++) begin
            if (w_cell == 3'(k)) begin
                w_code = r_shadow[6*k +: 6];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow   <= '0;
            r_vs_prev  <= 1'b1;
            r_sel      <= '0;
            r_ad       <= '0;
            r_lsby     <= '0;
            r_col_a    <= '0;
            r_cell_a   <= '0;
            r_in_win_a <= 1'b0;
            r_video_a  <= 1'b0;
            r_hs_a     <= 1'b1;
            r_vs_a     <= 1'b1;
        end else if (pixel_tick) begin
            r_vs_prev  <= vsync_in;
            if (w_frame_evt) begin
                r_shadow <= text_in;
            end
            r_sel      <= w_in_win ? w_code[5:2] : 4'd0;
            r_ad       <= w_in_win ? w_code[1:0] : 2'd0;
            r_lsby     <= w_in_win ? w_dy[3:0]   : 4'd0;
            r_col_a    <= w_dx[2:0];
            r_cell_a   <= w_cell;
            r_in_win_a <= w_in_win;
            r_video_a  <= video_on;
            r_hs_a     <= hsync_in;
            r_vs_a     <= vsync_in;
        end
    end

    // The ROM answers combinationally for the address held in stage A; bit 7 is column 0.
    assign w_glyph_bit = data[~r_col_a] & r_in_win_a;

`ifdef BLINK_CURSOR_EN
    logic [4:0] r_blink_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
        end else if (pixel_tick && w_frame_evt) begin
            r_blink_cnt <= r_blink_cnt + 5'd1;
        end
    end

    assign w_pix = w_glyph_bit ^ (r_in_win_a & r_blink_cnt[4] & (r_cell_a == cursor_pos));
`else
    logic w_unused_cursor;

    assign w_unused_cursor = ^{cursor_pos, r_cell_a};
    assign w_pix           = w_glyph_bit;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_b    <= 1'b0;
            r_in_win_b <= 1'b0;
            r_video_b  <= 1'b0;
            r_hs_b     <= 1'b1;
            r_vs_b     <= 1'b1;
        end else if (pixel_tick) begin
            r_pix_b    <= w_pix;
            r_in_win_b <= r_in_win_a;
            r_video_b  <= r_video_a;
            r_hs_b     <= r_hs_a;
            r_vs_b     <= r_vs_a;
        end
    end

    logic w_unused_coord;
    assign w_unused_coord = ^{w_dx[9:6], w_dy[9:4]};

    assign sel_caracter = r_sel;
    assign AD           = r_ad;
    assign lsby         = r_lsby;
    assign rgb          = !r_video_b ? 12'h000 : (r_pix_b ? FG : (r_in_win_b ? BG : 12'h000));
    assign hsync        = r_hs_b;
    assign vsync        = r_vs_b;

endmodule

// File: doc/vga_texto_render.md
VGA_TEXTO_RENDER -- requirements
Module: vga_texto_render

Interface
REQ-001 Parameter X0, default 256: left pixel column of the text window.
REQ-002 Parameter Y0, default 224: top pixel row of the text window.
REQ-003 Parameter FG, default 12'hFFF: foreground colour.
REQ-004 Parameter BG, default 12'h000: in-window background colour.
REQ-005 clk  in  1  system clock; the block has one clock, and reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pixel_tick  in  1  pixel enable, one clk wide, once per pixel.
REQ-008 video_on  in  1  active-video flag from the sync generator.
REQ-009 hsync_in, vsync_in  in  1 each  active-low syncs from the sync generator.
REQ-010 pixel_x, pixel_y  in  10 each  current pixel coordinate.
REQ-011 text_in  in  48  eight 6-bit character codes; code k is at [6k+5:6k], code = {sel[3:0], ad[1:0]}.
REQ-012 cursor_pos  in  3  cursor cell index; used only with BLINK_CURSOR_EN.
REQ-013 sel_caracter  out  4  character-ROM bank select.
REQ-014 AD  out  2  character-ROM glyph index within the bank.
REQ-015 lsby  out  4  character-ROM glyph row.
REQ-016 data  in  8  character-ROM row bits, combinational from sel_caracter/AD/lsby; bit 7 is the leftmost pixel.
REQ-017 rgb  out  12  pixel colour.
REQ-018 hsync, vsync  out  1 each  syncs delayed to align with rgb.

Function
REQ-019 The window SHALL be 8 cells of 8x16 pixels: X0 <= pixel_x < X0+64 and Y0 <= pixel_y < Y0+16.
REQ-020 In window: dx = pixel_x-X0, cell = dx[5:3], col = dx[2:0], row = (pixel_y-Y0)[3:0].
REQ-021 Pipeline state SHALL advance only on clk edges where pixel_tick=1; otherwise all registers hold.
REQ-022 Stage A SHALL register these values: sel_caracter/AD = shadow code of cell and lsby = row (all zero outside the window), plus col, in_win, video_on, hsync_in and vsync_in.
REQ-023 Stage B SHALL register pix = data[7-col_A] AND in_win_A, plus video_on, hsync and vsync from stage A.
REQ-024 rgb SHALL be registered at stage B: 0 if video_on_B=0, FG if pix=1, otherwise BG when in_win_B=1 and 0 when in_win_B=0.
REQ-025 Total latency SHALL be exactly 2 pixel_ticks from pixel_x/pixel_y/sync inputs to rgb/hsync/vsync.
REQ-026 A shadow copy of text_in SHALL load on the pixel_tick where vsync_in goes from 1 to 0 (the frame event); text_in changes mid-frame SHALL NOT affect the displayed frame.
REQ-027 Boundaries: pixel_x = X0+63 SHALL be in window; X0+64 and Y0+16 SHALL be out; pixel_x < X0 SHALL be out with no wrap of dx.
REQ-028 A frame event coinciding with an in-window pixel SHALL take effect from the next pixel_tick.

Reset
REQ-029 On reset, sel_caracter, AD, lsby and rgb SHALL be 0, and hsync and vsync SHALL be 1.
REQ-030 On reset, all pipeline flags and the shadow SHALL be 0, and the vsync edge detector SHALL be 1.
REQ-031 Reset asserted mid-line SHALL force the reset values in the next clk; output SHALL resume 2 pixel_ticks after release.

Configuration
REQ-032 Macro BLINK_CURSOR_EN defined: a 5-bit frame counter (reset value 0) SHALL increment on each frame event.
REQ-033 With BLINK_CURSOR_EN, while counter[4]=1, pix SHALL be inverted for in-window pixels of cell cursor_pos.
REQ-034 BLINK_CURSOR_EN undefined: the counter SHALL be absent, cursor_pos SHALL be ignored, and no inversion SHALL occur.

Verification
REQ-035 Reset then frame event with code{0}={4'd4,2'd1} ('1'); sweep pixel (X0..X0+7, Y0+1) -> rgb 0,0,0,FG,0,0,0,0 two ticks later; ROM address seen is sel=4, AD=1, lsby=1.
REQ-036 pixel_x=X0+64 and pixel_x=X0-1 at Y0+5 with video_on=1 -> sel_caracter=0 and rgb=0; pixel_x=X0+63 -> rgb=BG or FG per ROM bit 0.
REQ-037 Change text_in mid-frame -> rgb unchanged until after the next vsync_in 1->0; pixel_tick held 0 for 5 clk -> all outputs frozen.
REQ-038 vsync_in pulse low at tick N -> vsync output low at tick N+2 with equal width; same check for hsync.
REQ-039 Assert reset during an in-window pixel -> next clk rgb=0 and hsync=vsync=1; first valid rgb appears 2 ticks after release.
REQ-040 With BLINK_CURSOR_EN and cursor_pos=2: frames 0-15 cell 2 normal, frames 16-31 cell 2 inverted (blank row -> BG becomes FG), frame 32 normal again.
